fod_fcw_ramp: RTL and testbench

Frequency-change sequencer for the fractional output divider (FOD). It sits between the system control side and the FOD digital controller, and owns the `FCW_FOD` word and `DSM_EN` that drive it. A requested target FCW is not applied as a single jump. It is ramped in bounded steps with a programmable dwell per step, so the MMD/retimer/DTC datapath never sees a frequency step larger than `STEP`. After the target is reached, the block holds a settle window and then reports completion.

---
 rtl/fod_fcw_ramp.sv | 174 +++++++++++++++++
 tb/tb_fod_fcw_ramp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fod_fcw_ramp.sv
// FCW ramp sequencer for the fractional output divider: walks FCW_FOD toward a requested
// target in bounded steps with a per-step dwell, then settles. Optional macro: FOD_RAMP_CLAMP_EN.
module fod_fcw_ramp #(
  parameter int unsigned WI         = 6,
  parameter int unsigned WF         = 16,
  parameter int unsigned INIT_FCW   = 277217,
  parameter int unsigned MIN_FCW    = 4 * 65536,
  parameter int unsigned MAX_FCW    = 63 * 65536,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             req_i,
  input  logic [WI+WF-1:0] tgt_fcw_i,
  input  logic [WF-1:0]    step_i,
  input  logic [7:0]       dwell_i,
  input  logic             abort_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WI+WF-1:0] fcw_fod_o,
  output logic             dsm_en_o
);

  localparam int unsigned W  = WI + WF;
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [W-1:0]  InitFcw  = W'(INIT_FCW);
  localparam logic [SW-1:0] ScntLoad = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StRamp, StSettle} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  fcw_q, fcw_d;
  logic [W-1:0]  tgt_q, tgt_d;
  logic [W-1:0]  step_q, step_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          dsm_en_q;

  logic [W-1:0]  tgt_sel;
  logic          clamped;
  logic [W-1:0]  cap_diff;
  logic [W-1:0]  ramp_diff;

`ifdef FOD_RAMP_CLAMP_EN
  localparam logic [W-1:0] MinFcw = W'(MIN_FCW);
  localparam logic [W-1:0] MaxFcw = W'(MAX_FCW);

  always_comb begin
    tgt_sel = tgt_fcw_i;
    clamped = 1'b0;
    if (tgt_fcw_i < MinFcw) begin
      tgt_sel = MinFcw;
      clamped = 1'b1;
    end else if (tgt_fcw_i > MaxFcw) begin
      tgt_sel = MaxFcw;
      clamped = 1'b1;
    end
  end
`else
  assign tgt_sel = tgt_fcw_i;
  assign clamped = 1'b0;
`endif

  // Magnitude of a-b using a one-bit-wider difference; the sign bit picks the direction.
  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[W] ? (b - a) : d[W-1:0];
  endfunction

  assign cap_diff  = abs_diff(tgt_sel, fcw_q);
  assign ramp_diff = abs_diff(tgt_q, fcw_q);

  always_comb begin
    state_d = state_q;
    fcw_d   = fcw_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    dcnt_d  = dcnt_q;
    scnt_d  = scnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          tgt_d   = tgt_sel;
          step_d  = (step_i == '0) ? cap_diff : W'(step_i);
          dwell_d = dwell_i;
          dcnt_d  = dwell_i;
          scnt_d  = ScntLoad;
          ack_d   = 1'b1;
          err_d   = clamped;
          state_d = (tgt_sel == fcw_q) ? StSettle : StRamp;
        end
      end
      StRamp: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - 8'd1;
        end else if (ramp_diff <= step_q) begin
          fcw_d   = tgt_q;
          scnt_d  = ScntLoad;
          state_d = StSettle;
        end else begin
          // Strictly more than one step away, so neither direction can overshoot or wrap.
          fcw_d  = (tgt_q > fcw_q) ? fcw_q + step_q : fcw_q - step_q;
          dcnt_d = dwell_q;
        end
      end
      StSettle: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (scnt_q != '0) begin
          scnt_d = scnt_q - SW'(1);
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= StIdle;
      fcw_q    <= InitFcw;
      tgt_q    <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      dcnt_q   <= '0;
      scnt_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dsm_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcw_q    <= fcw_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      dcnt_q   <= dcnt_d;
      scnt_q   <= scnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dsm_en_q <= 1'b1;
    end
  end

  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign fcw_fod_o = fcw_q;
  assign dsm_en_o  = dsm_en_q;

endmodule

// File: tb/tb_fod_fcw_ramp.sv
// Scoreboard bench for fod_fcw_ramp: a step-list reference model queues expected ACK/update/DONE
// events with their cycle numbers; a negedge monitor pops and compares as the DUT emits them.
module tb_fod_fcw_ramp;

  localparam longint INIT = 277217;
  localparam longint MINF = 4 * 65536;
  localparam longint MAXF = 63 * 65536;
  localparam longint S    = 16;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        req = 1'b0;
  logic        abort = 1'b0;
  logic [21:0] tgt = '0;
  logic [15:0] step = '0;
  logic [7:0]  dwell = '0;
  logic        ack, busy, done, err, dsm_en;
  logic [21:0] fcw;

  fod_fcw_ramp dut (
    .clk_i    (clk),
    .arst_i   (arst),
    .req_i    (req),
    .tgt_fcw_i(tgt),
    .step_i   (step),
    .dwell_i  (dwell),
    .abort_i  (abort),
    .ack_o    (ack),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .fcw_fod_o(fcw),
    .dsm_en_o (dsm_en)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = ACK (value is ERR), 1 = FCW update (value is FCW), 2 = DONE (value is FCW)
  typedef struct {
    int     kind;
    longint cyc;
    longint val;
  } ev_t;

  ev_t    exp_q[$];
  longint upd_val[$];
  int     checks = 0;
  int     errors = 0;
  longint model_fcw = INIT;
  longint prev_fcw = INIT;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input longint c, input longint v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Reference: the list of FCW values the ramp visits, each one DWELL+1 cycles after the last.
  task automatic model(input longint c, input longint start, input longint traw,
                       input longint stp, input longint dw,
                       output longint done_c, output longint t);
    longint v, st, d;
    int     k;
    bit     e;
    t = traw;
    e = 1'b0;
`ifdef FOD_RAMP_CLAMP_EN
    if (t < MINF) begin
      t = MINF;
      e = 1'b1;
    end else if (t > MAXF) begin
      t = MAXF;
      e = 1'b1;
    end
`endif
    push_ev(0, c, longint'(e));
    st = (stp == 0) ? ((t > start) ? t - start : start - t) : stp;
    v = start;
    k = 0;
    upd_val.delete();
    while (v != t) begin
      d = (t > v) ? t - v : v - t;
      if (d <= st) v = t;
      else if (t > v) v = v + st;
      else v = v - st;
      k++;
      upd_val.push_back(v);
      push_ev(1, c + k * (dw + 1), v);
    end
    done_c = c + k * (dw + 1) + S;
    push_ev(2, done_c, t);
  endtask

  task automatic observe(input int kind, input longint v);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event: kind %0d value %0d at cycle %0d, expected none",
               kind, v, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event kind", kind, e.kind);
      chk("event cycle", cyc, e.cyc);
      chk("event value", v, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (arst) begin
      prev_fcw = fcw;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed event: kind %0d expected at cycle %0d, now %0d",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (ack) observe(0, longint'(err));
      if (longint'(fcw) != prev_fcw) observe(1, longint'(fcw));
      if (done) observe(2, longint'(fcw));
      prev_fcw = fcw;
    end
  end

  // mode 0: run to DONE; 1: ABORT after update k; 2: reset after update k
  task automatic run_txn(input longint traw, input longint stp, input longint dw,
                         input int mode, input int kin);
    longint c, dc, t, cut;
    int     k, m;
    @(negedge clk);
    tgt   = 22'(traw);
    step  = 16'(stp);
    dwell = 8'(dw);
    req   = 1'b1;
    c = cyc + 1;
    model(c, model_fcw, traw, stp, dw, dc, t);
    m = mode;
    k = kin;
    if (upd_val.size() == 0) m = 0;
    if (m != 0) begin
      if (k < 1) k = 1;
      if (k > upd_val.size()) k = upd_val.size();
      cut = c + k * (dw + 1);
      while (exp_q.size() > 0 && exp_q[$].cyc > cut) void'(exp_q.pop_back());
    end
    @(negedge clk);
    req   = 1'b0;
    tgt   = 22'($urandom);
    step  = 16'($urandom);
    dwell = 8'($urandom);
    if (m == 0) begin
      while (cyc < dc + 1) @(negedge clk);
      model_fcw = t;
    end else begin
      while (cyc < c + k * (dw + 1)) @(negedge clk);
      if (m == 1) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("busy after abort", longint'(busy), 0);
        chk("fcw held after abort", longint'(fcw), upd_val[k-1]);
        model_fcw = upd_val[k-1];
      end else begin
        #1 arst = 1'b1;
        #1;
        chk("fcw in reset", longint'(fcw), INIT);
        chk("dsm_en in reset", longint'(dsm_en), 0);
        chk("busy in reset", longint'(busy), 0);
        exp_q.delete();
        @(negedge clk);
        #3 arst = 1'b0;
        @(negedge clk);
        chk("dsm_en after release", longint'(dsm_en), 1);
        model_fcw = INIT;
      end
    end
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    longint c1, dc1, t1, c2, dc2, t2, tr, st, dw, delta;
    int     r;
    #12;
    chk("reset fcw", longint'(fcw), INIT);
    chk("reset dsm_en", longint'(dsm_en), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset ack", longint'(ack), 0);
    chk("reset done", longint'(done), 0);
    chk("reset err", longint'(err), 0);
    @(negedge clk);
    #3 arst = 1'b0;
    @(negedge clk);
    chk("dsm_en after first edge", longint'(dsm_en), 1);

    run_txn(64'h50000, 64'h1000, 3, 0, 0);
    chk("fcw after up-ramp", longint'(fcw), 64'h50000);
    run_txn(64'h40000, 0, 5, 0, 0);
    chk("fcw after direct jump", longint'(fcw), 64'h40000);
    run_txn(64'h50000, 64'h1000, 3, 2, 4);
    run_txn(64'h10000, 64'h4000, 1, 0, 0);
    run_txn(64'h30000, 64'h2000, 2, 2, 2);
    run_txn(64'h50000, 64'h1000, 3, 1, 5);
    chk("abort fcw value", longint'(fcw), INIT + 5 * 4096);
    run_txn(64'h48000, 64'h3000, 0, 0, 0);

    // Request held through a ramp; inputs change after ACK and feed only the second capture.
    @(negedge clk);
    tgt = 22'h60000; step = 16'h2000; dwell = 8'd2; req = 1'b1;
    c1 = cyc + 1;
    model(c1, model_fcw, 64'h60000, 64'h2000, 2, dc1, t1);
    c2 = dc1 + 1;
    model(c2, t1, 64'h58000, 64'h1800, 1, dc2, t2);
    @(negedge clk);
    tgt = 22'h58000; step = 16'h1800; dwell = 8'd1;
    while (cyc < c2) @(negedge clk);
    req = 1'b0;
    while (cyc < dc2 + 1) @(negedge clk);
    model_fcw = t2;

    run_txn(model_fcw, 64'h1000, 2, 0, 0);

    for (int i = 0; i < 20; i++) begin
      r  = int'($urandom_range(0, 9));
      dw = longint'($urandom_range(0, 7));
      st = ($urandom_range(0, 4) == 0) ? 0 : longint'($urandom_range(16'h1000, 16'hFFFF));
      if (r == 0) begin
        tr = longint'($urandom_range(0, 32'(MINF - 1)));
        if (st != 0 && st < 64'h8000) st = 64'h8000;
      end else if (r == 1) begin
        tr = longint'($urandom_range(32'(MAXF), 32'h3FFFFF));
        if (st != 0 && st < 64'h8000) st = 64'h8000;
      end else if (r == 2) begin
        tr = model_fcw;
      end else begin
        delta = longint'($urandom_range(0, 32'hC0000)) - 64'h60000;
        tr = model_fcw + delta;
        if (tr < MINF) tr = MINF;
        if (tr > MAXF) tr = MAXF;
      end
      r = int'($urandom_range(0, 3));
      run_txn(tr, st, dw, (r == 0) ? 1 : 0, int'($urandom_range(1, 40)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard drained", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
